// File: rtl/elevator_call_scheduler_if.sv
// Call/target bundle between the button latches, the scheduler and the
// floor/motion controller. The scheduler takes the slave side.
interface elevator_call_scheduler_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
);
  logic [NUM_FLOORS-1:0] hall_up;
  logic [NUM_FLOORS-1:0] hall_dn;
  logic [NUM_FLOORS-1:0] car_call;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  arrive;
  logic                  car_idle;
  logic [FLOOR_W-1:0]    target_floor;
  logic                  target_valid;
  logic                  move_dir;
  logic                  open_req;
  logic [NUM_FLOORS-1:0] pend_up;
  logic [NUM_FLOORS-1:0] pend_dn;
  logic [NUM_FLOORS-1:0] pend_car;

  modport master (
    output hall_up, hall_dn, car_call, cur_floor, arrive, car_idle,
    input  target_floor, target_valid, move_dir, open_req,
    input  pend_up, pend_dn, pend_car
  );

  modport slave (
    input  hall_up, hall_dn, car_call, cur_floor, arrive, car_idle,
    output target_floor, target_valid, move_dir, open_req,
    output pend_up, pend_dn, pend_car
  );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Per-car SCAN call scheduler: latches hall/car calls, picks the next target
// floor while preserving travel direction, and requests door openings.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
) (
  input logic                     clk,
  input logic                     reset,
  elevator_call_scheduler_if.slave bus
);
  localparam int unsigned NF = NUM_FLOORS;
  localparam int          IW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  // Top floor has no up button, bottom floor has no down button.
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, UP, DOWN, DWELL} state_t;
  state_t state, state_nx;

  logic [NUM_FLOORS-1:0] pend_up, pend_dn, pend_car, pend_any, here_oh;
  logic [NUM_FLOORS-1:0] clr_up, clr_dn, clr_car;
  logic [FLOOR_W-1:0]    tgt_q, tgt_nx, up_first, up_far, dn_first, dn_far;
  logic                  up_first_ok, up_far_ok, dn_first_ok, dn_far_ok;
  logic                  above, below, here, near_up;
  logic                  valid_q, valid_nx, dir_q, dir_nx, open_q, open_nx;
  int unsigned           cfi, na, nb;

  // Scan pending calls relative to the (clamped) current floor.
  always_comb begin
    cfi         = (32'(bus.cur_floor) >= NF) ? NF - 1 : 32'(bus.cur_floor);
    pend_any    = pend_up | pend_dn | pend_car;
    here_oh     = '0;
    above       = 1'b0;
    below       = 1'b0;
    na          = 0;
    nb          = 0;
    up_first    = '0;
    up_far      = '0;
    dn_first    = '0;
    dn_far      = '0;
    up_first_ok = 1'b0;
    up_far_ok   = 1'b0;
    dn_first_ok = 1'b0;
    dn_far_ok   = 1'b0;
    for (int unsigned i = 0; i < NF; i++) begin
      if (i == cfi) here_oh[i[IW-1:0]] = 1'b1;
      if (i > cfi) begin
        if (pend_any[i[IW-1:0]] && !above) begin
          above = 1'b1;
          na    = i;
        end
        if ((pend_car[i[IW-1:0]] || pend_up[i[IW-1:0]]) && !up_first_ok) begin
          up_first_ok = 1'b1;
          up_first    = FLOOR_W'(i);
        end
        if (pend_dn[i[IW-1:0]]) begin
          up_far_ok = 1'b1;
          up_far    = FLOOR_W'(i);
        end
      end
      if (i < cfi) begin
        if (pend_any[i[IW-1:0]]) begin
          below = 1'b1;
          nb    = i;
        end
        if (pend_car[i[IW-1:0]] || pend_dn[i[IW-1:0]]) begin
          dn_first_ok = 1'b1;
          dn_first    = FLOOR_W'(i);
        end
        if (pend_up[i[IW-1:0]] && !dn_far_ok) begin
          dn_far_ok = 1'b1;
          dn_far    = FLOOR_W'(i);
        end
      end
    end
    here    = |(pend_any & here_oh);
    near_up = (na - cfi) <= (cfi - nb);
  end

  // Next state, stop clearing and registered output values.
  always_comb begin
    state_nx = state;
    clr_up   = '0;
    clr_dn   = '0;
    clr_car  = '0;
    tgt_nx   = tgt_q;
    valid_nx = 1'b0;
    dir_nx   = dir_q;
    open_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.car_idle) begin
          if (here) begin
            clr_up   = here_oh;
            clr_dn   = here_oh;
            clr_car  = here_oh;
            open_nx  = 1'b1;
            state_nx = DWELL;
          end else if (above && (!below || near_up)) begin
            state_nx = UP;
          end else if (below) begin
            state_nx = DOWN;
          end
        end
      end
      UP: begin
        if (bus.arrive) begin
          clr_car = here_oh;
          clr_up  = here_oh;
          if (!above) begin
            clr_dn = here_oh;
            dir_nx = 1'b0;
          end
          open_nx  = 1'b1;
          state_nx = DWELL;
        end else if (pend_any == '0) begin
          state_nx = IDLE;
        end
      end
      DOWN: begin
        if (bus.arrive) begin
          clr_car = here_oh;
          clr_dn  = here_oh;
          if (!below) begin
            clr_up = here_oh;
            dir_nx = 1'b1;
          end
          open_nx  = 1'b1;
          state_nx = DWELL;
        end else if (pend_any == '0) begin
          state_nx = IDLE;
        end
      end
      DWELL: begin
        if (!bus.car_idle) begin
          if (here) begin
            clr_up  = here_oh;
            clr_dn  = here_oh;
            clr_car = here_oh;
            open_nx = 1'b1;
          end
        end else if (dir_q ? above : below) begin
          state_nx = dir_q ? UP : DOWN;
        end else if (dir_q ? below : above) begin
          state_nx = dir_q ? DOWN : UP;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Target follows the state being entered; it is held once the car is
    // already at or past every call in the travel direction, so a late arrive
    // pulse still finds the sweep in progress.
    if (state_nx == UP) begin
      valid_nx = 1'b1;
      dir_nx   = 1'b1;
      if (up_first_ok)    tgt_nx = up_first;
      else if (up_far_ok) tgt_nx = up_far;
    end else if (state_nx == DOWN) begin
      valid_nx = 1'b1;
      dir_nx   = 1'b0;
      if (dn_first_ok)    tgt_nx = dn_first;
      else if (dn_far_ok) tgt_nx = dn_far;
    end
  end

  // State, call latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pend_up  <= '0;
      pend_dn  <= '0;
      pend_car <= '0;
      tgt_q    <= '0;
      valid_q  <= 1'b0;
      dir_q    <= 1'b1;
      open_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      pend_up  <= (pend_up  | (bus.hall_up & UP_MASK)) & ~clr_up;
      pend_dn  <= (pend_dn  | (bus.hall_dn & DN_MASK)) & ~clr_dn;
      pend_car <= (pend_car | bus.car_call)             & ~clr_car;
      tgt_q    <= tgt_nx;
      valid_q  <= valid_nx;
      dir_q    <= dir_nx;
      open_q   <= open_nx;
    end
  end

  assign bus.target_floor = tgt_q;
  assign bus.target_valid = valid_q;
  assign bus.move_dir     = dir_q;
  assign bus.open_req     = open_q;
  assign bus.pend_up      = pend_up;
  assign bus.pend_dn      = pend_dn;
  assign bus.pend_car     = pend_car;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a floor-level reference model.
module tb_elevator_call_scheduler;
  localparam int NF = 4;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  elevator_call_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bif ();
  elevator_call_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one flag per floor and button kind, plus the car mode.
  string mode = "idle";
  bit    m_up[NF];
  bit    m_dn[NF];
  bit    m_car[NF];
  int    m_tgt = 0;
  bit    m_valid = 1'b0;
  bit    m_dir = 1'b1;
  bit    m_open = 1'b0;

  function automatic bit call_at(int f);
    return m_up[f] | m_dn[f] | m_car[f];
  endfunction

  function automatic bit any_call();
    for (int f = 0; f < NF; f++) if (call_at(f)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nearest_above(int cf);
    for (int f = cf + 1; f < NF; f++) if (call_at(f)) return f;
    return -1;
  endfunction

  function automatic int nearest_below(int cf);
    for (int f = cf - 1; f >= 0; f--) if (call_at(f)) return f;
    return -1;
  endfunction

  function automatic int up_target(int cf);
    for (int f = cf + 1; f < NF; f++) if (m_car[f] || m_up[f]) return f;
    for (int f = NF - 1; f > cf; f--) if (m_dn[f]) return f;
    return -1;
  endfunction

  function automatic int dn_target(int cf);
    for (int f = cf - 1; f >= 0; f--) if (m_car[f] || m_dn[f]) return f;
    for (int f = 0; f < cf; f++) if (m_up[f]) return f;
    return -1;
  endfunction

  function automatic logic [NF-1:0] pack(input bit v[NF]);
    logic [NF-1:0] r;
    for (int f = 0; f < NF; f++) r[f] = v[f];
    return r;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int cf, a, b, t, ahead, behind;
    bit clr_c, clr_u, clr_d;
    string nxt;
    logic [NF-1:0] hu, hd, cc;
    hu = bif.hall_up;
    hd = bif.hall_dn;
    cc = bif.car_call;
    if (reset) begin
      for (int f = 0; f < NF; f++) begin
        m_up[f] = 0; m_dn[f] = 0; m_car[f] = 0;
      end
      mode = "idle"; m_tgt = 0; m_valid = 0; m_dir = 1; m_open = 0;
      return;
    end
    cf = int'(bif.cur_floor);
    if (cf >= NF) cf = NF - 1;
    clr_c = 0; clr_u = 0; clr_d = 0;
    nxt = mode;
    m_open = 0;
    a = nearest_above(cf);
    b = nearest_below(cf);
    if (mode == "idle") begin
      if (bif.car_idle) begin
        if (call_at(cf)) begin
          clr_c = 1; clr_u = 1; clr_d = 1; m_open = 1; nxt = "dwell";
        end else if (a >= 0 && (b < 0 || (a - cf) <= (cf - b))) nxt = "up";
        else if (b >= 0) nxt = "down";
      end
    end else if (mode == "up") begin
      if (bif.arrive) begin
        clr_c = 1; clr_u = 1;
        if (a < 0) begin clr_d = 1; m_dir = 0; end
        m_open = 1; nxt = "dwell";
      end else if (!any_call()) nxt = "idle";
    end else if (mode == "down") begin
      if (bif.arrive) begin
        clr_c = 1; clr_d = 1;
        if (b < 0) begin clr_u = 1; m_dir = 1; end
        m_open = 1; nxt = "dwell";
      end else if (!any_call()) nxt = "idle";
    end else begin
      if (!bif.car_idle) begin
        if (call_at(cf)) begin clr_c = 1; clr_u = 1; clr_d = 1; m_open = 1; end
      end else begin
        ahead  = m_dir ? a : b;
        behind = m_dir ? b : a;
        if (ahead >= 0)       nxt = m_dir ? "up" : "down";
        else if (behind >= 0) nxt = m_dir ? "down" : "up";
        else                  nxt = "idle";
      end
    end
    m_valid = (nxt == "up") || (nxt == "down");
    if (nxt == "up") begin
      m_dir = 1; t = up_target(cf); if (t >= 0) m_tgt = t;
    end else if (nxt == "down") begin
      m_dir = 0; t = dn_target(cf); if (t >= 0) m_tgt = t;
    end
    for (int f = 0; f < NF; f++) begin
      m_up[f]  = (m_up[f]  || (hu[f] && f != NF - 1)) && !(clr_u && f == cf);
      m_dn[f]  = (m_dn[f]  || (hd[f] && f != 0))      && !(clr_d && f == cf);
      m_car[f] = (m_car[f] || cc[f])                  && !(clr_c && f == cf);
    end
    mode = nxt;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pend_up",      32'(bif.pend_up),      32'(pack(m_up)));
    chk("pend_dn",      32'(bif.pend_dn),      32'(pack(m_dn)));
    chk("pend_car",     32'(bif.pend_car),     32'(pack(m_car)));
    chk("target_floor", 32'(bif.target_floor), 32'(m_tgt));
    chk("target_valid", 32'(bif.target_valid), 32'(m_valid));
    chk("move_dir",     32'(bif.move_dir),     32'(m_dir));
    chk("open_req",     32'(bif.open_req),     32'(m_open));
  endtask

  task automatic drive(logic [NF-1:0] hu, logic [NF-1:0] hd, logic [NF-1:0] cc,
                       int cf, bit arr, bit idl);
    bif.hall_up   = hu;
    bif.hall_dn   = hd;
    bif.car_call  = cc;
    bif.cur_floor = FW'(cf);
    bif.arrive    = arr;
    bif.car_idle  = idl;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive('0, '0, '0, 0, 0, 1);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int cf_r;
    drive('0, '0, '0, 0, 0, 1);
    #1;

    // Reset values
    do_reset();
    chk("rst_pend_car", 32'(bif.pend_car), 32'h0);
    chk("rst_valid",    32'(bif.target_valid), 32'h0);
    chk("rst_dir",      32'(bif.move_dir), 32'h1);
    chk("rst_tgt",      32'(bif.target_floor), 32'h0);

    // Car call to 3 from floor 0
    drive('0, '0, 4'b1000, 0, 0, 1); step();
    chk("t1_latch", 32'(bif.pend_car), 32'b1000);
    drive('0, '0, '0, 0, 0, 1); step();
    chk("t1_tgt", 32'(bif.target_floor), 32'd3);
    chk("t1_valid", 32'(bif.target_valid), 32'd1);
    drive('0, '0, '0, 1, 0, 0); step();
    drive('0, '0, '0, 2, 0, 0); step();
    drive('0, '0, '0, 3, 0, 0); step();
    drive('0, '0, '0, 3, 1, 0); step();
    chk("t1_arr_pend", 32'(bif.pend_car), 32'h0);
    chk("t1_arr_open", 32'(bif.open_req), 32'h1);
    drive('0, '0, '0, 3, 0, 0); step();
    chk("t1_open_pulse", 32'(bif.open_req), 32'h0);

    // Retarget to a closer up call
    do_reset();
    drive('0, '0, 4'b1000, 0, 0, 1); step();
    drive('0, '0, '0, 0, 0, 1); step();
    drive(4'b0010, '0, '0, 0, 0, 0); step();
    drive('0, '0, '0, 0, 0, 0); step();
    chk("t2_retgt", 32'(bif.target_floor), 32'd1);
    drive('0, '0, '0, 1, 1, 0); step();
    chk("t2_clr_up", 32'(bif.pend_up), 32'h0);
    chk("t2_keep_car", 32'(bif.pend_car), 32'b1000);
    chk("t2_dir", 32'(bif.move_dir), 32'h1);
    drive('0, '0, '0, 1, 0, 1); step();
    chk("t2_resume", 32'(bif.target_floor), 32'd3);

    // Nearer call wins, then reversal
    do_reset();
    drive(4'b0001, 4'b1000, '0, 2, 0, 1); step();
    drive('0, '0, '0, 2, 0, 1); step();
    chk("t3_dir_up", 32'(bif.move_dir), 32'h1);
    chk("t3_tgt3", 32'(bif.target_floor), 32'd3);
    drive('0, '0, '0, 3, 1, 0); step();
    chk("t3_rev_dir", 32'(bif.move_dir), 32'h0);
    drive('0, '0, '0, 3, 0, 1); step();
    chk("t3_tgt0", 32'(bif.target_floor), 32'd0);
    chk("t3_valid", 32'(bif.target_valid), 32'h1);

    // End of sweep at a down-only call
    do_reset();
    drive('0, 4'b0100, '0, 0, 0, 1); step();
    drive('0, '0, '0, 0, 0, 1); step();
    chk("t4_tgt", 32'(bif.target_floor), 32'd2);
    drive('0, '0, '0, 1, 0, 0); step();
    drive('0, '0, '0, 2, 1, 0); step();
    chk("t4_clr_dn", 32'(bif.pend_dn), 32'h0);
    chk("t4_dir", 32'(bif.move_dir), 32'h0);
    drive('0, '0, '0, 2, 0, 1); step();
    chk("t4_idle", 32'(bif.target_valid), 32'h0);

    // Press during the servicing edge, held into the next cycle
    do_reset();
    drive('0, '0, 4'b1000, 0, 0, 1); step();
    drive('0, '0, '0, 0, 0, 1); step();
    drive('0, '0, '0, 1, 0, 0); step();
    drive(4'b0100, '0, '0, 2, 1, 0); step();
    chk("t5_clr_wins", 32'(bif.pend_up), 32'h0);
    drive(4'b0100, '0, '0, 2, 0, 0); step();
    chk("t5_relatch", 32'(bif.pend_up), 32'b0100);
    drive('0, '0, '0, 2, 0, 0); step();
    chk("t5_reopen", 32'(bif.open_req), 32'h1);

    // Reset mid-travel
    do_reset();
    drive('0, '0, 4'b1110, 0, 0, 1); step();
    drive('0, '0, '0, 0, 0, 1); step();
    drive('0, '0, '0, 1, 0, 0); step();
    chk("t6_moving", 32'(bif.target_valid), 32'h1);
    reset = 1'b1;
    drive('0, '0, '0, 1, 0, 0); step();
    reset = 1'b0;
    chk("t6_pend", 32'(bif.pend_car), 32'h0);
    chk("t6_valid", 32'(bif.target_valid), 32'h0);
    drive('0, '0, '0, 1, 0, 0); step();

    // Random traffic against the model
    cf_r = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1 && cf_r < NF - 1) cf_r++;
        else if (cf_r > 0) cf_r--;
      end
      reset = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 7) == 0) ? NF'($urandom) : '0,
            ($urandom_range(0, 7) == 0) ? NF'($urandom) : '0,
            ($urandom_range(0, 7) == 0) ? NF'($urandom) : '0,
            cf_r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1));
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Latches hall and car calls and selects the next target floor using a direction-preserving sweep (SCAN).
- Drives the car's target floor, travel direction and door-open requests.
- Sits between the button/call latches and the floor/motion controller.
- One instance per car; it replaces ad-hoc target selection inside the floor controller.

Parameters:
NUM_FLOORS, 4, number of served floors (floor 0 = lowest)
FLOOR_W, 2, width of floor index; 2**FLOOR_W >= NUM_FLOORS

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
hall_up  input  NUM_FLOORS  up-call buttons, bit i = floor i; bit NUM_FLOORS-1 ignored
hall_dn  input  NUM_FLOORS  down-call buttons; bit 0 ignored
car_call  input  NUM_FLOORS  in-car floor buttons
cur_floor  input  FLOOR_W  current car floor from floor controller
arrive  input  1  one-cycle pulse: car has stopped at cur_floor
car_idle  input  1  car stopped, door closed, ready for a new target
target_floor  output  FLOOR_W  selected destination, valid when target_valid=1
target_valid  output  1  a target is being served
move_dir  output  1  1 = up, 0 = down; held while idle
open_req  output  1  one-cycle pulse: open door at cur_floor
pend_up, pend_dn, pend_car  output  NUM_FLOORS each  latched call registers (button lamps)

Behaviour:
- Reset (synchronous, active-high):
  - All pend_* = 0, state = IDLE.
  - target_floor = 0, target_valid = 0, move_dir = 1, open_req = 0.
  - Reset mid-travel drops all calls and any target immediately on that edge.
- Latching: each cycle, pend_x <= (pend_x | input_x) & ~clear_x. Ignored bits (pend_up[top], pend_dn[0]) are never set.
- Clear rule: clearing applies only in the cycle a stop is serviced.
  - Clear has priority over a set in that cycle; a press held into the next cycle re-latches.
- All outputs are registered.
- States: IDLE, UP, DOWN, DWELL.
- "above" = any pending bit (any of the three registers) at a floor > cur_floor. "below" = the same for floors < cur_floor. "here" = any bit at cur_floor.
- IDLE, when car_idle=1, evaluated in this priority order:
  - here: clear pend_car[cur_floor], pend_up[cur_floor] and pend_dn[cur_floor]; pulse open_req next cycle; go to DWELL.
  - above only: go to UP.
  - below only: go to DOWN.
  - both: go toward the nearer call; on an equal-distance tie, go UP.
  - No pending calls: remain IDLE.
- UP:
  - move_dir = 1, target_valid = 1.
  - target_floor = lowest floor > cur_floor with pend_car or pend_up set; if none, the highest floor > cur_floor with pend_dn set.
  - Target is recomputed every cycle, so a new closer call ahead retargets with 1-cycle latency.
- DOWN: mirror of UP.
  - target_floor = highest floor < cur_floor with pend_car or pend_dn set; if none, the lowest floor < cur_floor with pend_up set.
- arrive in UP or DOWN:
  - Stop at cur_floor regardless of target_floor.
  - Clear pend_car[cur_floor] and the hall bit for the current direction.
  - If there are no calls beyond cur_floor in the current direction, also clear the opposite hall bit at cur_floor and invert move_dir.
  - target_valid <= 0; open_req pulses 1 cycle after arrive; go to DWELL.
- arrive in IDLE or DWELL: ignored.
- DWELL:
  - Wait for car_idle=1, then re-evaluate: calls ahead in move_dir → keep that direction (UP or DOWN); else calls behind → reverse; else IDLE.
  - A call at cur_floor while in DWELL with car_idle=0 is cleared and re-pulses open_req (door re-open).
- Combination check: target_valid=1 only in UP/DOWN. If the calls feeding the target vanish (only possible via reset), go to IDLE.
- cur_floor >= NUM_FLOORS is treated as the top floor.

Test Plan:
- Reset, then car_call[3] pulse with cur_floor=0, car_idle=1 → pend_car=4'b1000 next cycle; UP, target_floor=3, move_dir=1; on arrive at floor 3 → pend_car=0, open_req 1-cycle pulse, DWELL.
- Moving UP toward 3 from floor 0; hall_up[1] pressed → target_floor becomes 1 within 1 cycle; arrive at 1 clears pend_up[1] only, then resumes UP to 3.
- cur_floor=2 idle; simultaneous hall_dn[3] and hall_up[0] → UP chosen (distance 1 < 2); after serving 3, the direction reverses and target_floor=0.
- Arrive at floor 2 going UP with only pend_dn[2] left → both hall bits at 2 cleared, move_dir=0, then IDLE after car_idle.
- Press hall_up[2] in the same cycle as arrive at floor 2 going up → bit stays clear; press held next cycle → re-latched and open_req re-pulses.
- Assert reset while in UP with three calls pending → next cycle all pend_*=0, target_valid=0, IDLE.
